// File: rtl/psola_scheduler.sv
// Frame scheduler for a PSOLA pitch shifter: fills a ping-pong window buffer,
// launches the psola engine per completed frame and plays out its result.
module psola_scheduler #(
  parameter int WINDOW_SIZE    = 2048,
  parameter int MIN_PERIOD     = 20,
  parameter int MAX_PERIOD     = 1024,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         sample_valid_in,
  output logic                         wr_en_out,
  output logic [$clog2(WINDOW_SIZE):0] wr_addr_out,
  input  logic                         period_valid_in,
  input  logic [11:0]                  period_in,
  output logic                         psola_start_out,
  output logic                         psola_bank_out,
  output logic [11:0]                  period_out,
  input  logic                         psola_done_in,
  input  logic [11:0]                  psola_len_in,
  input  logic                         rd_tick_in,
  output logic                         rd_valid_out,
  output logic [11:0]                  rd_addr_out,
  output logic                         busy_out,
  output logic                         overrun_out,
  output logic                         timeout_out,
  output logic [15:0]                  skip_count_out,
  output logic [2:0]                   state_out
);

  localparam int AW = $clog2(WINDOW_SIZE);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [11:0]   MIN_P = 12'(MIN_PERIOD);
  localparam logic [11:0]   MAX_P = 12'(MAX_PERIOD);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_PLAY   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [AW-1:0] r_fill_idx;
  logic          r_fill_bank;
  logic [11:0]   r_period;
  logic          r_period_seen;
  logic [11:0]   r_period_out;
  logic          r_bank;
  logic [15:0]   r_skip;
  logic          r_overrun;
  logic          r_timeout;
  logic [TW-1:0] r_timer;
  logic [11:0]   r_len;
  logic [11:0]   r_rd_idx;

  logic          w_frame_ready;
  logic          w_period_ok;
  logic          w_timer_end;
  logic          w_last_tick;

  // Window size is a power of two, so an all-ones index is the last sample.
  assign w_frame_ready = sample_valid_in && (&r_fill_idx);
  assign w_period_ok   = r_period_seen && (r_period >= MIN_P) && (r_period <= MAX_P);
  assign w_timer_end   = (r_timer == T_END);
  assign w_last_tick   = rd_tick_in && (r_rd_idx == (r_len - 12'd1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    psola_start_out = 1'b0;
    rd_valid_out    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame_ready) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_period_ok ? S_LAUNCH : S_IDLE;
      end
      S_LAUNCH: begin
        psola_start_out = 1'b1;
        w_next          = S_RUN;
      end
      S_RUN: begin
        if (psola_done_in) begin
          w_next = (psola_len_in == 12'd0) ? S_IDLE : S_PLAY;
        end else if (w_timer_end) begin
          w_next = S_IDLE;
        end
      end
      S_PLAY: begin
        rd_valid_out = rd_tick_in;
        if (w_last_tick) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Window filling never stalls, whatever the control state is doing.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fill_idx    <= '0;
      r_fill_bank   <= 1'b0;
      r_period      <= 12'd0;
      r_period_seen <= 1'b0;
    end else begin
      if (sample_valid_in) begin
        r_fill_idx <= r_fill_idx + AW'(1);
        if (&r_fill_idx) r_fill_bank <= ~r_fill_bank;
      end
      if (period_valid_in) begin
        r_period      <= period_in;
        r_period_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_period_out <= 12'd0;
      r_bank       <= 1'b0;
      r_skip       <= 16'd0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_timer      <= '0;
      r_len        <= 12'd0;
      r_rd_idx     <= 12'd0;
    end else begin
      if (w_frame_ready && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_frame_ready) r_bank <= r_fill_bank;
        end
        S_CHECK: begin
          if (w_period_ok) begin
            r_period_out <= r_period;
          end else if (r_skip != 16'hFFFF) begin
            r_skip <= r_skip + 16'd1;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
        end
        S_RUN: begin
          if (psola_done_in) begin
            r_len    <= psola_len_in;
            r_rd_idx <= 12'd0;
          end else if (w_timer_end) begin
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_PLAY: begin
          if (rd_tick_in) r_rd_idx <= r_rd_idx + 12'd1;
        end
        default: ;
      endcase
    end
  end

  assign wr_en_out      = sample_valid_in;
  assign wr_addr_out    = {r_fill_bank, r_fill_idx};
  assign psola_bank_out = r_bank;
  assign period_out     = r_period_out;
  assign rd_addr_out    = r_rd_idx;
  assign busy_out       = (r_state != S_IDLE);
  assign overrun_out    = r_overrun;
  assign timeout_out    = r_timeout;
  assign skip_count_out = r_skip;
  assign state_out      = r_state;

endmodule

// File: tb/tb_psola_scheduler.sv
// Bench for psola_scheduler: directed scenarios with literal checks plus random
// traffic compared every cycle against a timestamp-based behavioural model.
module tb_psola_scheduler;

  localparam int WS = 16;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv = 1'b0;
  logic        pv = 1'b0;
  logic [11:0] period = 12'd0;
  logic        done = 1'b0;
  logic [11:0] len = 12'd0;
  logic        tick = 1'b0;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic        start;
  logic        bank;
  logic [11:0] period_o;
  logic        rd_valid;
  logic [11:0] rd_addr;
  logic        busy;
  logic        overrun;
  logic        timeout;
  logic [15:0] skip;
  logic [2:0]  dbg_state;

  psola_scheduler #(
    .WINDOW_SIZE(WS), .MIN_PERIOD(20), .MAX_PERIOD(1024), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst), .sample_valid_in(sv),
    .wr_en_out(wr_en), .wr_addr_out(wr_addr),
    .period_valid_in(pv), .period_in(period),
    .psola_start_out(start), .psola_bank_out(bank), .period_out(period_o),
    .psola_done_in(done), .psola_len_in(len),
    .rd_tick_in(tick), .rd_valid_out(rd_valid), .rd_addr_out(rd_addr),
    .busy_out(busy), .overrun_out(overrun), .timeout_out(timeout),
    .skip_count_out(skip), .state_out(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] idle_code = 3'd0;
  bit idle_known = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // A job is described by the cycle its frame arrived; check, launch and
  // run windows are fixed offsets from that cycle.
  longint cyc = 0;
  bit     m_live = 1'b0;
  int     m_n, m_frame_at, m_len, m_played, m_per, m_pout, m_bank, m_skip;
  bit     m_busy, m_ok, m_have_len, m_seen, m_ovr, m_tmo;

  always @(negedge clk) begin : cmp
    bit chk_c, run_c, play_c, e_start, e_rdv, fr;
    chk_c   = m_busy && (cyc == m_frame_at + 1);
    e_start = m_busy && m_ok && (cyc == m_frame_at + 2);
    run_c   = m_busy && m_ok && (cyc > m_frame_at + 2) && !m_have_len;
    play_c  = m_busy && m_have_len;
    e_rdv   = play_c && tick;
    if (m_live) begin
      chk("wr_en", 32'(wr_en), 32'(sv));
      chk("wr_addr", 32'(wr_addr), 32'(m_n % (2 * WS)));
      chk("start", 32'(start), 32'(e_start));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
      if (e_rdv) chk("rd_addr", 32'(rd_addr), 32'(m_played));
      chk("period_out", 32'(period_o), 32'(m_pout));
      chk("bank", 32'(bank), 32'(m_bank));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("timeout", 32'(timeout), 32'(m_tmo));
      chk("skip", 32'(skip), 32'(m_skip));
      if (idle_known) chk("state_idle", 32'(dbg_state == idle_code), 32'(!m_busy));
    end
    if (rst) begin
      m_live = 1'b1;
      m_n = 0; m_busy = 0; m_ok = 0; m_have_len = 0; m_seen = 0; m_per = 0;
      m_pout = 0; m_bank = 0; m_skip = 0; m_ovr = 0; m_tmo = 0;
      m_frame_at = -10; m_len = 0; m_played = 0;
    end else if (m_live) begin
      fr = sv && (m_n % WS == WS - 1);
      if (fr) begin
        if (!m_busy) begin
          m_busy = 1; m_frame_at = int'(cyc); m_bank = (m_n / WS) % 2;
          m_ok = 0; m_have_len = 0;
        end else begin
          m_ovr = 1;
        end
      end
      if (chk_c) begin
        if (m_seen && m_per >= 20 && m_per <= 1024) begin
          m_ok = 1; m_pout = m_per;
        end else begin
          if (m_skip < 65535) m_skip++;
          m_busy = 0;
        end
      end
      if (run_c) begin
        if (done) begin
          if (len == 12'd0) m_busy = 0;
          else begin m_have_len = 1; m_len = int'(len); m_played = 0; end
        end else if (cyc == m_frame_at + 2 + TO) begin
          m_tmo = 1; m_busy = 0;
        end
      end
      if (e_rdv) begin
        m_played++;
        if (m_played == m_len) m_busy = 0;
      end
      if (pv) begin m_per = int'(period); m_seen = 1; end
      if (sv) m_n++;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_period(input logic [11:0] p);
    step(); pv = 1'b1; period = p;
    step(); pv = 1'b0;
  endtask

  // Returns inside the cycle after the last sample (the check cycle).
  task automatic drive_samples(input int n);
    for (int i = 0; i < n; i++) begin
      step(); sv = 1'b1;
    end
    step(); sv = 1'b0;
  endtask

  task automatic pulse_done(input logic [11:0] l);
    step(); done = 1'b1; len = l;
    step(); done = 1'b0;
  endtask

  task automatic play_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(); tick = 1'b1;
      @(negedge clk);
      chk("tick_valid", 32'(rd_valid), 32'd1);
      chk("tick_addr", 32'(rd_addr), 32'(i));
      step(); tick = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_skip"}, 32'(skip), 32'd0);
    chk({tag, "_period_out"}, 32'(period_o), 32'd0);
    chk({tag, "_bank"}, 32'(bank), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    idle_code = dbg_state;
    idle_known = 1'b1;

    // valid period, first frame from bank 0
    set_period(12'd100);
    drive_samples(WS);
    @(negedge clk);
    chk("launch_not_early", 32'(start), 32'd0);
    @(negedge clk);
    chk("launch_pulse", 32'(start), 32'd1);
    chk("launch_period", 32'(period_o), 32'd100);
    chk("launch_bank", 32'(bank), 32'd0);

    // done len 5 then five ticks
    pulse_done(12'd5);
    play_ticks(5);
    chk("play_done_idle", 32'(busy), 32'd0);

    // period below minimum -> frame skipped
    set_period(12'd5);
    drive_samples(WS);
    @(negedge clk);
    @(negedge clk);
    chk("skip_no_start", 32'(start), 32'd0);
    chk("skip_count", 32'(skip), 32'd1);
    chk("skip_idle", 32'(busy), 32'd0);

    // timeout, then a normal launch
    set_period(12'd100);
    drive_samples(WS);
    repeat (TO + 6) @(negedge clk);
    chk("timeout_flag", 32'(timeout), 32'd1);
    chk("timeout_idle", 32'(busy), 32'd0);
    drive_samples(WS);
    @(negedge clk);
    @(negedge clk);
    chk("relaunch_pulse", 32'(start), 32'd1);
    chk("relaunch_bank", 32'(bank), 32'd1);
    pulse_done(12'd3);
    play_ticks(3);
    chk("relaunch_idle", 32'(busy), 32'd0);

    // frames arriving during playout are dropped
    drive_samples(WS);
    @(negedge clk);
    @(negedge clk);
    chk("ovr_launch", 32'(start), 32'd1);
    pulse_done(12'd4);
    drive_samples(2 * WS);
    @(negedge clk);
    chk("overrun_flag", 32'(overrun), 32'd1);
    chk("overrun_busy", 32'(busy), 32'd1);
    play_ticks(4);
    chk("overrun_idle", 32'(busy), 32'd0);

    // reset in RUN aborts; later done is ignored
    drive_samples(WS);
    @(negedge clk);
    @(negedge clk);
    chk("rst_launch", 32'(start), 32'd1);
    step();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check_reset_values("run_reset");
    pulse_done(12'd5);
    @(negedge clk);
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_rd", 32'(rd_valid), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      step();
      rst  = ($urandom_range(0, 1499) == 0);
      sv   = ($urandom_range(0, 3) == 0);
      pv   = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 6))
        0: period = 12'd5;
        1: period = 12'd19;
        2: period = 12'd20;
        3: period = 12'd1024;
        4: period = 12'd1025;
        5: period = 12'($urandom_range(21, 1023));
        default: period = 12'($urandom_range(0, 4095));
      endcase
      done = ($urandom_range(0, 29) == 0);
      len  = 12'($urandom_range(0, 6));
      tick = ($urandom_range(0, 1) == 1);
    end
    step();
    rst = 1'b0; sv = 1'b0; pv = 1'b0; done = 1'b0; tick = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psola_scheduler.md
PSOLA_SCHEDULER -- requirements
Module: psola_scheduler

Interface
REQ-001 SHALL have parameter WINDOW_SIZE, default 2048, meaning samples per analysis frame (power of two).
REQ-002 SHALL have parameter MIN_PERIOD, default 20, meaning the smallest accepted pitch period in samples.
REQ-003 SHALL have parameter MAX_PERIOD, default 1024, meaning the largest accepted pitch period in samples.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65536, meaning the maximum number of cycles to wait for psola done.
REQ-005 clk_in  input  1  single clock; all logic on rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 sample_valid_in  input  1  one new input audio sample this cycle.
REQ-008 wr_en_out  output  1  window-buffer write strobe, equal to sample_valid_in.
REQ-009 wr_addr_out  output  $clog2(WINDOW_SIZE)+1  {bank, index} write address into the ping-pong window buffer.
REQ-010 period_valid_in  input  1  pitch detector has a new period estimate.
REQ-011 period_in  input  12  pitch period in samples.
REQ-012 psola_start_out  output  1  one-cycle start pulse to the psola engine (its new_signal).
REQ-013 psola_bank_out  output  1  window bank the psola engine reads; held from launch until return to IDLE.
REQ-014 period_out  output  12  period handed to psola; held stable from launch until return to IDLE.
REQ-015 psola_done_in  input  1  psola engine finished.
REQ-016 psola_len_in  input  12  output window length; valid with psola_done_in.
REQ-017 rd_tick_in  input  1  output sample-rate strobe.
REQ-018 rd_valid_out  output  1  read the output buffer at rd_addr_out this cycle.
REQ-019 rd_addr_out  output  12  playout read address.
REQ-020 busy_out  output  1  state != IDLE.
REQ-021 overrun_out  output  1  sticky: a frame completed while not IDLE.
REQ-022 timeout_out  output  1  sticky: psola done not seen within TIMEOUT_CYCLES.
REQ-023 skip_count_out  output  16  saturating count of frames dropped for an invalid or absent period.

Function
REQ-024 Fill counter SHALL increment on each sample_valid_in and wrap at WINDOW_SIZE-1->0, toggling the bank bit; wrap asserts internal frame_ready for one cycle for the bank just completed.
REQ-025 Filling SHALL run in every state and never stall.
REQ-026 On period_valid_in, period_in SHALL be latched and a period_seen flag set; a latch in the same cycle as frame_ready SHALL be used for that frame.
REQ-027 States SHALL be IDLE, CHECK, LAUNCH, RUN, PLAY.
REQ-028 IDLE: frame_ready SHALL latch the completed bank and move to CHECK.
REQ-029 CHECK: with period_seen and MIN_PERIOD<=period<=MAX_PERIOD, SHALL latch period_out and go to LAUNCH; otherwise SHALL increment skip_count_out (saturating at 0xFFFF) and go to IDLE.
REQ-030 LAUNCH: psola_start_out SHALL be 1 for exactly this one cycle; next state RUN; timer cleared.
REQ-031 RUN: psola_done_in SHALL latch psola_len_in and go to PLAY, or go to IDLE if len==0; otherwise, once the timer reaches TIMEOUT_CYCLES-1, SHALL set timeout_out and go to IDLE.
REQ-032 PLAY: each rd_tick_in SHALL pulse rd_valid_out for one cycle with rd_addr_out = 0,1,..,len-1; the tick issuing len-1 SHALL return to IDLE.
REQ-033 rd_tick_in outside PLAY SHALL be ignored (rd_valid_out=0).
REQ-034 frame_ready in any state other than IDLE SHALL set overrun_out, and that frame SHALL be discarded.
REQ-035 psola_done_in outside RUN SHALL be ignored.
REQ-036 Control-output latency: psola_start_out SHALL rise exactly 2 cycles after the frame_ready cycle (IDLE->CHECK->LAUNCH).

Reset
REQ-037 rst_in SHALL force state IDLE and, from the next cycle, psola_start_out=0, rd_valid_out=0, busy_out=0, overrun_out=0, timeout_out=0, skip_count_out=0, period_out=0, psola_bank_out=0, fill counter=0, bank=0 and period_seen=0.
REQ-038 rst_in SHALL take priority over all inputs and SHALL abort any state mid-operation, including RUN and PLAY.

Verification (WINDOW_SIZE=16)
REQ-039 period 100 latched, 16 samples -> one start pulse 2 cycles after the 16th sample, period_out=100, psola_bank_out=0.
REQ-040 done with len=5, then 5 rd_ticks -> rd_addr 0..4, then busy_out=0.
REQ-041 period 5 (below MIN_PERIOD), 16 samples -> no start pulse, skip_count_out=1.
REQ-042 done withheld for TIMEOUT_CYCLES -> timeout_out=1, state IDLE, next frame launches normally.
REQ-043 32 samples while in PLAY -> overrun_out=1 and no extra start pulse.
REQ-044 rst_in asserted in RUN -> all outputs at reset values next cycle, and a later done is ignored.
